reg_bank_slave: RTL and testbench

//  Parametrised register-bank slave; next generation of the single-port register DUT. Adds a

---
 rtl/reg_bank_slave.sv | 134 +++++++++++++
 tb/tb_reg_bank_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_slave.sv
// Valid/ready register bank: writes complete in one cycle, reads answer after RD_LAT cycles
// and hold until rsp_ready. Define REG_BANK_BYTE_STROBE_EN to add the byte_en write strobe.
module reg_bank_slave #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data_in,
`ifdef REG_BANK_BYTE_STROBE_EN
  input  logic [DATA_W/8-1:0] byte_en,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   data_out,
  output logic                rsp_err,
  output logic                wr_err
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              rsp_vld_q;
  logic              rsp_err_q;
  logic              wr_err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              req_in_range;
  logic              rd_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word_d;

  assign req_ready    = rst_n && (state_q == IDLE);
  assign accept       = req_valid && req_ready;
  // Range checks use the full address so high addresses never alias onto low words.
  assign req_in_range = {1'b0, address} < DEPTH_C;
  assign rd_addr      = (RD_LAT == 1) ? address : addr_q;
  assign rd_in_range  = {1'b0, rd_addr} < DEPTH_C;
  assign rd_word      = rd_in_range ? mem_q[rd_addr[IDX_W-1:0]] : '0;

`ifdef REG_BANK_BYTE_STROBE_EN
  always_comb begin
    wr_word_d = mem_q[address[IDX_W-1:0]];
    for (int b = 0; b < DATA_W/8; b++) begin
      if (byte_en[b]) wr_word_d[8*b +: 8] = data_in[8*b +: 8];
    end
  end
`else
  assign wr_word_d = data_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept && write && req_in_range) begin
      mem_q[address[IDX_W-1:0]] <= wr_word_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (write) begin
              wr_err_q <= !req_in_range;
            end else begin
              addr_q <= address;
              cnt_q  <= CNT_INIT;
              if (RD_LAT == 1) begin
                dout_q    <= rd_word;
                rsp_err_q <= !rd_in_range;
                rsp_vld_q <= 1'b1;
                state_q   <= RSP;
              end else begin
                state_q <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            dout_q    <= rd_word;
            rsp_err_q <= !rd_in_range;
            rsp_vld_q <= 1'b1;
            state_q   <= RSP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RSP: begin
          // data_out keeps the last response after the handshake; only the error flag clears.
          if (rsp_ready) begin
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign data_out  = dout_q;
  assign rsp_err   = rsp_err_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_reg_bank_slave.sv
// Bench for reg_bank_slave: directed scenarios plus random traffic, all checked each cycle
// against a transaction-level model of the register bank.
module tb_reg_bank_slave;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 2;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              write = 1'b0;
  logic              rsp_ready = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_err;
  logic              wr_err;
  logic [DATA_W-1:0] data_out;
`ifdef REG_BANK_BYTE_STROBE_EN
  logic [NB-1:0]     byte_en = '1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  reg_bank_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .write(write), .address(address), .data_in(data_in),
`ifdef REG_BANK_BYTE_STROBE_EN
    .byte_en(byte_en),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .data_out(data_out),
    .rsp_err(rsp_err), .wr_err(wr_err)
  );

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding read, tracked by its age in cycles.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_busy, m_wr_err, m_rsp_err;
  int                m_age;
  logic [DATA_W-1:0] m_rsp_data, m_last_dout;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 0; m_wr_err = 0; m_rsp_err = 0; m_age = 0;
    m_rsp_data = '0; m_last_dout = '0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    bit vld;
    int a;
    if (rst_n) begin
      vld = m_busy && (m_age >= RD_LAT);
      a = int'(address);
      m_wr_err = 0;
      if (m_busy) begin
        if (vld && rsp_ready) begin
          m_busy = 0;
          m_last_dout = m_rsp_data;
        end else begin
          m_age++;
        end
      end else if (req_valid) begin
        if (write) begin
          if (a < DEPTH) begin
`ifdef REG_BANK_BYTE_STROBE_EN
            for (int b = 0; b < NB; b++)
              if (byte_en[b]) m_mem[a][8*b +: 8] = data_in[8*b +: 8];
`else
            m_mem[a] = data_in;
`endif
          end else begin
            m_wr_err = 1;
          end
        end else begin
          m_busy = 1;
          m_age = 0;
          m_rsp_err = (a >= DEPTH);
          m_rsp_data = m_rsp_err ? '0 : m_mem[a];
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_vld;
    exp_vld = rst_n && m_busy && (m_age >= RD_LAT);
    chk1("req_ready", req_ready, rst_n && !m_busy);
    chk1("rsp_valid", rsp_valid, exp_vld);
    chk1("wr_err", wr_err, rst_n && m_wr_err);
    chk1("rsp_err", rsp_err, exp_vld && m_rsp_err);
    chkd("data_out", data_out, exp_vld ? m_rsp_data : m_last_dout);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

  // Called and returns at posedge+1; holds the request until it is accepted.
  task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int t = 0;
    req_valid = 1'b1; write = wr; address = a; data_in = d;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk1("accept_timeout", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; write = 1'b0;
  endtask

  task automatic wait_rsp();
    int t = 0;
    @(negedge clk);
    while (!(rsp_valid && rsp_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk1("rsp_timeout", rsp_valid && rsp_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("reset_ready", req_ready, 1'b1);
    chkd("reset_dout", data_out, '0);
    @(posedge clk); #1;

    // Write then immediate read; response exactly RD_LAT edges after acceptance.
    rsp_ready = 1'b1;
    send(1'b1, 8'h05, 16'h1234);
    send(1'b0, 8'h05, 16'h0000);
    @(negedge clk); chk1("lat_e0", rsp_valid, 1'b0);
    @(negedge clk); chk1("lat_e1", rsp_valid, 1'b0);
    @(negedge clk); chk1("lat_e2", rsp_valid, 1'b1);
    chkd("rd_1234", data_out, 16'h1234);
    chk1("rd_1234_err", rsp_err, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk1("ready_after_hs", req_ready, 1'b1);
    @(posedge clk); #1;

    // Response back-pressure.
    rsp_ready = 1'b0;
    send(1'b0, 8'h05, 16'h0000);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("stall_vld", rsp_valid, 1'b1);
      chkd("stall_dout", data_out, 16'h1234);
      chk1("stall_rdy", req_ready, 1'b0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk); @(posedge clk);
    @(negedge clk);
    chk1("stall_release_rdy", req_ready, 1'b1);
    chk1("stall_release_vld", rsp_valid, 1'b0);
    @(posedge clk); #1;

    // Out-of-range write/read and range boundary.
    send(1'b1, 8'h20, 16'hBEEF);
    @(negedge clk); chk1("wr_err_pulse", wr_err, 1'b1);
    @(negedge clk); chk1("wr_err_clear", wr_err, 1'b0);
    @(posedge clk); #1;
    send(1'b0, 8'h20, 16'h0000);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk1("oor_vld", rsp_valid, 1'b1);
    chkd("oor_dout", data_out, 16'h0000);
    chk1("oor_err", rsp_err, 1'b1);
    @(posedge clk); #1;
    send(1'b0, 8'h00, 16'h0000); wait_rsp();
    chkd("no_alias", data_out, 16'h0000);
    send(1'b1, 8'h0F, 16'h5A5A);
    @(negedge clk); chk1("edge_in_range", wr_err, 1'b0);
    @(posedge clk); #1;
    send(1'b1, 8'h10, 16'hA5A5);
    @(negedge clk); chk1("edge_out_range", wr_err, 1'b1);
    @(posedge clk); #1;
    send(1'b0, 8'h0F, 16'h0000); wait_rsp();
    chkd("edge_rd", data_out, 16'h5A5A);

    // Reset while a response is being held.
    rsp_ready = 1'b0;
    send(1'b0, 8'h05, 16'h0000);
    repeat (3) @(posedge clk);
    #1 chk1("pre_reset_vld", rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_vld_drop", rsp_valid, 1'b0);
    chk1("async_rdy_drop", req_ready, 1'b0);
    chkd("async_dout_clr", data_out, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      send(1'b0, ADDR_W'(a), 16'h0000);
      wait_rsp();
      chkd("rd_all_zero", data_out, '0);
    end

    // Reset one cycle before the response would appear.
    send(1'b1, 8'h07, 16'hCAFE);
    send(1'b0, 8'h07, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("no_late_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(1'b0, 8'h07, 16'h0000); wait_rsp();
    chkd("post_reset_word", data_out, 16'h0000);

`ifdef REG_BANK_BYTE_STROBE_EN
    byte_en = '1;
    send(1'b1, 8'h01, 16'hFFFF);
    byte_en = 2'b01;
    send(1'b1, 8'h01, 16'h00AA);
    byte_en = 2'b00;
    send(1'b1, 8'h01, 16'h1234);
    @(negedge clk); chk1("be_zero_no_err", wr_err, 1'b0);
    @(posedge clk); #1;
    byte_en = '1;
    send(1'b0, 8'h01, 16'h0000); wait_rsp();
    chkd("byte_strobe", data_out, 16'hFFAA);
`endif

    // Random traffic; reads sometimes left outstanding so the next request stalls behind them.
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic wr;
      logic [ADDR_W-1:0] a;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wr = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(0, 255))
                                      : ADDR_W'($urandom_range(0, 19));
`ifdef REG_BANK_BYTE_STROBE_EN
      byte_en = NB'($urandom);
`endif
      send(wr, a, DATA_W'($urandom));
      if (!wr && $urandom_range(0, 1) == 1) wait_rsp();
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
